// File: rtl/mem_unit_pkg.sv
// Shared types and parameter defaults for the mem_unit request/response memory.
package mem_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int WAIT_CYCLES_MAX = 15;
  localparam int DATA_W_DEF      = 8;
  localparam int ADDR_W_DEF      = 13;
  localparam int DEPTH_DEF       = 8192;
  localparam int WAIT_CYCLES_DEF = 1;

endpackage

// File: rtl/mem_unit_array.sv
// Single-port word storage: synchronous write, registered read, contents never reset.
module mem_unit_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8192,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_unit.sv
// Request/response memory front end with programmable access latency.
// Optional out-of-range address flagging is enabled by defining MEM_BOUNDS_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting down the added access latency
// RESP  | response held until the requester takes it
module mem_unit
  import mem_unit_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(WAIT_CYCLES_MAX + 1);
  localparam logic [CW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  mem_state_t        state, state_d;
  logic [CW-1:0]     cnt;
  logic              wr_q, err_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;

  logic [31:0]       addr_ext;
  logic [AW-1:0]     idx_d;
  logic              err_d;
  logic              accept, go_resp, in_idle;
  logic              cur_wr, cur_err;
  logic              a_we, a_re;
  logic [AW-1:0]     a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;

  assign addr_ext = 32'(req_addr);
  assign idx_d    = AW'(addr_ext % 32'(DEPTH));

`ifdef MEM_BOUNDS_CHECK_EN
  assign err_d = (addr_ext >= 32'(DEPTH));
`else
  assign err_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req_valid) state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (cnt == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!wr_q && !err_q) rsp_rdata = a_rdata;
      end
      default: ;
    endcase
  end

  assign accept  = req_valid && req_ready;
  assign go_resp = (state != RESP) && (state_d == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt     <= WAIT_LOAD;
      wr_q    <= req_write;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= req_wdata;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // With zero added latency the array is accessed on the accept edge, so use the live request.
  assign in_idle = (state == IDLE);
  assign a_addr  = in_idle ? idx_d     : idx_q;
  assign a_wdata = in_idle ? req_wdata : wdata_q;
  assign cur_wr  = in_idle ? req_write : wr_q;
  assign cur_err = in_idle ? err_d     : err_q;
  assign a_we    = go_resp && cur_wr && !cur_err;
  assign a_re    = go_resp && !cur_wr && !cur_err;

  mem_unit_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (a_we),
    .re   (a_re),
    .addr (a_addr),
    .wdata(a_wdata),
    .rdata(a_rdata)
  );

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: four instances covering latency 1/0/15 and a 1000-word array.
module tb_mem_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       rsp_ready;
  logic       req_write;
  logic [12:0] req_addr;
  logic [7:0] req_wdata;
  logic       rv_in  [4];
  logic       rq_rdy [4];
  logic       rs_v   [4];
  logic       rs_e   [4];
  logic [7:0] rs_d   [4];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_unit #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .req_valid(rv_in[0]), .req_ready(rq_rdy[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rs_v[0]), .rsp_ready(rsp_ready), .rsp_rdata(rs_d[0]), .rsp_err(rs_e[0]));

  mem_unit #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .req_valid(rv_in[1]), .req_ready(rq_rdy[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rs_v[1]), .rsp_ready(rsp_ready), .rsp_rdata(rs_d[1]), .rsp_err(rs_e[1]));

  mem_unit #(.WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst(rst), .req_valid(rv_in[2]), .req_ready(rq_rdy[2]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rs_v[2]), .rsp_ready(rsp_ready), .rsp_rdata(rs_d[2]), .rsp_err(rs_e[2]));

  mem_unit #(.DEPTH(1000), .WAIT_CYCLES(1)) dut_d1k (
    .clk(clk), .rst(rst), .req_valid(rv_in[3]), .req_ready(rq_rdy[3]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rs_v[3]), .rsp_ready(rsp_ready), .rsp_rdata(rs_d[3]), .rsp_err(rs_e[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance k and wait (bounded) for the response.
  task automatic txn(input int k, input logic wr, input logic [12:0] a,
                     input logic [7:0] d, input int exp_lat);
    int n;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    chk("req_ready_before", 32'(rq_rdy[k]), 32'd1);
    rv_in[k] = 1'b1;
    @(posedge clk); #1;
    rv_in[k] = 1'b0;
    n = 1;
    while (!rs_v[k] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
  endtask

  task automatic release_rsp();
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 4; i++) rv_in[i] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rs_v[0]), 32'd0);
    chk("rst_rsp_rdata", 32'(rs_d[0]), 32'd0);
    chk("rst_rsp_err",   32'(rs_e[0]), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(rq_rdy[0]), 32'd1);

    // Latency 1: write then read back
    txn(0, 1'b1, 13'd3, 8'hE7, 2);
    chk("w3_err",   32'(rs_e[0]), 32'd0);
    chk("w3_rdata", 32'(rs_d[0]), 32'd0);
    release_rsp();
    txn(0, 1'b0, 13'd3, 8'h00, 2);
    chk("r3_rdata", 32'(rs_d[0]), 32'hE7);
    chk("r3_err",   32'(rs_e[0]), 32'd0);
    release_rsp();

    // Latency 0
    txn(1, 1'b1, 13'd7, 8'h11, 1);
    release_rsp();
    txn(1, 1'b0, 13'd7, 8'h00, 1);
    chk("w0_r7_rdata", 32'(rs_d[1]), 32'h11);
    release_rsp();

    // Latency 15
    txn(2, 1'b1, 13'd4, 8'h22, 16);
    release_rsp();
    txn(2, 1'b0, 13'd4, 8'h00, 16);
    chk("w15_r4_rdata", 32'(rs_d[2]), 32'h22);
    release_rsp();

    // Back-pressure: response held, stray request ignored
    rsp_ready = 1'b0;
    txn(0, 1'b0, 13'd3, 8'h00, 2);
    req_write = 1'b1;
    req_addr  = 13'd3;
    req_wdata = 8'h00;
    rv_in[0]  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(rs_v[0]),   32'd1);
      chk("stall_rdata", 32'(rs_d[0]),   32'hE7);
      chk("stall_ready", 32'(rq_rdy[0]), 32'd0);
    end
    rv_in[0]  = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", 32'(rs_v[0]),   32'd0);
    chk("stall_release_ready", 32'(rq_rdy[0]), 32'd1);
    txn(0, 1'b0, 13'd3, 8'h00, 2);
    chk("stray_write_ignored", 32'(rs_d[0]), 32'hE7);
    release_rsp();

    // Reset during WAIT drops the pending write
    txn(0, 1'b1, 13'd10, 8'h5A, 2);
    release_rsp();
    req_write = 1'b1;
    req_addr  = 13'd10;
    req_wdata = 8'h96;
    rv_in[0]  = 1'b1;
    @(posedge clk); #1;
    rv_in[0] = 1'b0;
    chk("in_wait_not_ready", 32'(rq_rdy[0]), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", 32'(rs_v[0]), 32'd0);
    chk("abort_rsp_rdata", 32'(rs_d[0]), 32'd0);
    chk("abort_rsp_err",   32'(rs_e[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(rq_rdy[0]), 32'd1);
    @(posedge clk); #1;
    txn(0, 1'b0, 13'd10, 8'h00, 2);
    chk("abort_r10_rdata", 32'(rs_d[0]), 32'h5A);
    release_rsp();

    // DEPTH=1000: addresses past the end
    txn(3, 1'b1, 13'd5, 8'h3C, 2);
    release_rsp();
    txn(3, 1'b0, 13'd1005, 8'h00, 2);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("oob_r1005_err",   32'(rs_e[3]), 32'd1);
    chk("oob_r1005_rdata", 32'(rs_d[3]), 32'h00);
`else
    chk("wrap_r1005_err",   32'(rs_e[3]), 32'd0);
    chk("wrap_r1005_rdata", 32'(rs_d[3]), 32'h3C);
`endif
    release_rsp();
    txn(3, 1'b1, 13'd1005, 8'h77, 2);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("oob_w1005_err", 32'(rs_e[3]), 32'd1);
`else
    chk("wrap_w1005_err", 32'(rs_e[3]), 32'd0);
`endif
    release_rsp();
    txn(3, 1'b0, 13'd5, 8'h00, 2);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("oob_r5_rdata", 32'(rs_d[3]), 32'h3C);
`else
    chk("wrap_r5_rdata", 32'(rs_d[3]), 32'h77);
`endif
    chk("r5_err", 32'(rs_e[3]), 32'd0);
    release_rsp();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 13, request address width.
REQ-003 SHALL have parameter DEPTH, default 8192, number of words, where DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, added access latency.
REQ-005 SHALL have port clk, input, 1: the single clock, rising-edge active.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid, input, 1: request present.
REQ-008 SHALL have port req_ready, output, 1: unit can accept a request.
REQ-009 SHALL have port req_write, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, ADDR_W: word address.
REQ-011 SHALL have port req_wdata, input, DATA_W: write data.
REQ-012 SHALL have port rsp_valid, output, 1: response present.
REQ-013 SHALL have port rsp_ready, input, 1: requester takes the response.
REQ-014 SHALL have port rsp_rdata, output, DATA_W: read data, 0 for writes.
REQ-015 SHALL have port rsp_err, output, 1: address error flag.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge when req_valid=1 and req_ready=1, capturing write, addr and wdata.
REQ-019 SHALL transition on accept: IDLE->WAIT when WAIT_CYCLES>0, else IDLE->RESP.
REQ-020 SHALL load a wait counter with WAIT_CYCLES-1 on accept, decrement it each cycle in WAIT, and go WAIT->RESP on the edge where the counter equals 0.
REQ-021 SHALL commit a write to the array, and sample read data, on the edge entering RESP.
REQ-022 SHALL assert rsp_valid=1 throughout RESP, with rsp_rdata and rsp_err held stable.
REQ-023 SHALL go RESP->IDLE on the edge where rsp_ready=1, so rsp_valid is first seen WAIT_CYCLES+1 cycles after accept.
REQ-024 SHALL ignore req_valid outside IDLE; there is no request queueing.
REQ-025 SHALL return new data to a read following a write to the same address.
REQ-026 SHALL leave array contents unchanged on reads.

Reset
REQ-027 SHALL put the FSM in IDLE and drive rsp_valid=0, rsp_rdata=0, rsp_err=0 and the wait counter to 0 while rst=1, with req_ready=1 after rst deasserts.
REQ-028 SHALL abort an in-flight operation on reset asserted in WAIT: a pending write is dropped and the array is unchanged.
REQ-029 SHALL NOT reset array contents.

Configuration
REQ-030 SHALL, with MEM_BOUNDS_CHECK_EN defined, flag any accepted request with req_addr >= DEPTH with rsp_err=1 and rsp_rdata=0, perform no write, and keep the same latency.
REQ-031 SHALL, without MEM_BOUNDS_CHECK_EN, use address modulo DEPTH and tie rsp_err to 0.

Structure
REQ-032 SHALL place the FSM state typedef (mem_state_t), the WAIT_CYCLES maximum and the parameter defaults in package mem_unit_pkg.
REQ-033 SHALL implement the storage as sub-module mem_unit_array, with synchronous write, registered read, and parameters DATA_W and DEPTH.

Verification
REQ-034 SHALL test: WAIT_CYCLES=1, write addr 3 data 0xE7 with rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0.
REQ-035 SHALL test: read addr 3 after that write -> rsp_rdata=0xE7, 2-cycle latency.
REQ-036 SHALL test: WAIT_CYCLES=0, read -> rsp_valid on the cycle after accept; WAIT_CYCLES=15 -> 16 cycles.
REQ-037 SHALL test: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout, IDLE one cycle after rsp_ready=1.
REQ-038 SHALL test: write addr 10 data 0x96, rst pulsed during WAIT -> outputs 0, then read addr 10 returns the prior contents, not 0x96.
REQ-039 SHALL test: DEPTH=1000, read addr 1005 -> rsp_err=1 with MEM_BOUNDS_CHECK_EN; without it, data of addr 5 and rsp_err=0.
